// File: rtl/rf_prime_pkg.sv
// rf_prime_pkg: shared types and default sizes for the prime-modulus
// register file. Provides the bulk-load state type and the default
// modulus width, table depth and read lane count.
package rf_prime_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } ld_state_e;

   localparam int RF_XLEN  = 33;
   localparam int RF_DEPTH = 128;
   localparam int RF_LANES = 2;

endpackage

// File: rtl/rf_prime_ld_fsm.sv
// rf_prime_ld_fsm: streaming bulk-load engine for the prime table.
// Accepts a base address and a word count, then writes one stream word per
// accepted beat into consecutive entries (wrapping), yielding to external
// single-word writes.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   wr_en             external write this cycle (takes priority over load)
//   ld_start          begin a load (ignored unless idle)
//   ld_base/ld_count  first entry / number of words (0..DEPTH)
//   ld_valid/ld_data  stream word handshake and payload
//   ld_we/ld_wadr/ld_wdata  array write request produced by the engine
//   ld_ready/ld_busy/ld_done  stream ready, engine active, completion pulse
module rf_prime_ld_fsm
   import rf_prime_pkg::*;
#(
   parameter int XLEN    = RF_XLEN,
   parameter int AR_BITS = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic               ld_start,
   input  logic [AR_BITS-1:0] ld_base,
   input  logic [AR_BITS:0]   ld_count,
   input  logic               ld_valid,
   input  logic [XLEN-1:0]    ld_data,
   output logic               ld_we,
   output logic [AR_BITS-1:0] ld_wadr,
   output logic [XLEN-1:0]    ld_wdata,
   output logic               ld_ready,
   output logic               ld_busy,
   output logic               ld_done
);

   localparam logic [AR_BITS-1:0] PTR_ONE = AR_BITS'(1);
   localparam logic [AR_BITS:0]   REM_ONE = (AR_BITS + 1)'(1);

   ld_state_e          state;
   logic [AR_BITS-1:0] ptr;
   logic [AR_BITS:0]   rem;

   assign ld_ready = (state == LOAD) & ~wr_en;
   assign ld_busy  = (state != IDLE);
   assign ld_done  = (state == DONE);
   assign ld_we    = ld_valid & ld_ready;
   assign ld_wadr  = ptr;
   assign ld_wdata = ld_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (ld_start) state <= (ld_count == '0) ? DONE : LOAD;
            LOAD:    if (ld_we && rem == REM_ONE) state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // ptr/rem are always reloaded on ld_start before they are consumed,
   // so they carry no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && ld_start) begin
         ptr <= ld_base;
         rem <= ld_count;
      end else if (ld_we) begin
         ptr <= ptr + PTR_ONE;
         rem <= rem - REM_ONE;
      end
   end

endmodule

// File: rtl/rf_prime_bank.sv
// rf_prime_bank: prime-modulus register file for the RNS datapath.
// Holds DEPTH moduli of XLEN bits and returns LANES consecutive entries
// (wrapping modulo DEPTH) one cycle after a read request, with per-entry
// valid tracking, optional write-to-read forwarding and a bulk-load engine.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   rd_en, rd_adr               read request and base address
//   rd_data, rd_valid, rd_miss  lane i = entry (rd_adr+i), update strobe,
//                               lane i never written since reset
//   wr_en, wr_adr, wr_data      single-word write (wins over load)
//   ld_start, ld_base, ld_count bulk load command
//   ld_valid, ld_data, ld_ready stream handshake
//   ld_busy, ld_done            load engine status
module rf_prime_bank
   import rf_prime_pkg::*;
#(
   parameter int XLEN    = RF_XLEN,
   parameter int DEPTH   = RF_DEPTH,
   parameter int AR_BITS = $clog2(DEPTH),
   parameter int LANES   = RF_LANES,
   parameter int FWD     = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rd_en,
   input  logic [AR_BITS-1:0]      rd_adr,
   output logic [LANES*XLEN-1:0]   rd_data,
   output logic                    rd_valid,
   output logic [LANES-1:0]        rd_miss,
   input  logic                    wr_en,
   input  logic [AR_BITS-1:0]      wr_adr,
   input  logic [XLEN-1:0]         wr_data,
   input  logic                    ld_start,
   input  logic [AR_BITS-1:0]      ld_base,
   input  logic [AR_BITS:0]        ld_count,
   input  logic                    ld_valid,
   input  logic [XLEN-1:0]         ld_data,
   output logic                    ld_ready,
   output logic                    ld_busy,
   output logic                    ld_done
);

   logic [XLEN-1:0]    mem [DEPTH];
   logic [DEPTH-1:0]   vmap;

   logic               ld_we;
   logic [AR_BITS-1:0] ld_wadr;
   logic [XLEN-1:0]    ld_wdata;

   logic               we;
   logic [AR_BITS-1:0] wadr;
   logic [XLEN-1:0]    wdata;

   rf_prime_ld_fsm #(
      .XLEN    (XLEN),
      .AR_BITS (AR_BITS)
   ) u_ld_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .ld_start (ld_start),
      .ld_base  (ld_base),
      .ld_count (ld_count),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_we    (ld_we),
      .ld_wadr  (ld_wadr),
      .ld_wdata (ld_wdata),
      .ld_ready (ld_ready),
      .ld_busy  (ld_busy),
      .ld_done  (ld_done)
   );

   // The load engine already drops ld_ready while wr_en is high, so the
   // two sources never collide; the mux only picks the active one.
   assign we    = wr_en | ld_we;
   assign wadr  = wr_en ? wr_adr  : ld_wadr;
   assign wdata = wr_en ? wr_data : ld_wdata;

   always_ff @(posedge clk) begin
      if (we) mem[wadr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)  vmap <= '0;
      else if (we) vmap[wadr] <= 1'b1;
   end

   // ---- stage p0: lane addresses, array lookup, forwarding ----
   logic [AR_BITS-1:0] lane_adr_p0  [LANES];
   logic [XLEN-1:0]    lane_data_p0 [LANES];
   logic [LANES-1:0]   lane_miss_p0;

   always_comb begin
      lane_miss_p0 = '0;
      for (int i = 0; i < LANES; i++) begin
         // AR_BITS-bit add gives the modulo-DEPTH wrap for free
         lane_adr_p0[i] = rd_adr + AR_BITS'(i);
         if (FWD != 0 && we && wadr == lane_adr_p0[i]) begin
            lane_data_p0[i] = wdata;
            lane_miss_p0[i] = 1'b0;
         end else begin
            lane_data_p0[i] = mem[lane_adr_p0[i]];
            lane_miss_p0[i] = ~vmap[lane_adr_p0[i]];
         end
      end
   end

   // ---- stage p1: registered read result ----
   logic [LANES*XLEN-1:0] rd_data_p1;
   logic [LANES-1:0]      rd_miss_p1;
   logic                  vld_p1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_p1 <= '0;
         rd_miss_p1 <= '1;
         vld_p1     <= 1'b0;
      end else begin
         vld_p1 <= rd_en;
         if (rd_en) begin
            for (int i = 0; i < LANES; i++) begin
               rd_data_p1[i*XLEN +: XLEN] <= lane_data_p0[i];
            end
            rd_miss_p1 <= lane_miss_p0;
         end
      end
   end

   assign rd_data  = rd_data_p1;
   assign rd_miss  = rd_miss_p1;
   assign rd_valid = vld_p1;

endmodule

// File: tb/tb_rf_prime_bank.sv
module tb_rf_prime_bank;

   localparam int XLEN    = 33;
   localparam int DEPTH   = 128;
   localparam int AR_BITS = 7;
   localparam int LANES   = 2;
   localparam int DW      = LANES * XLEN;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n;
   logic               rd_en;
   logic [AR_BITS-1:0] rd_adr;
   logic               wr_en;
   logic [AR_BITS-1:0] wr_adr;
   logic [XLEN-1:0]    wr_data;
   logic               ld_start;
   logic [AR_BITS-1:0] ld_base;
   logic [AR_BITS:0]   ld_count;
   logic               ld_valid;
   logic [XLEN-1:0]    ld_data;

   logic [DW-1:0]    rd_data,  rd_data0;
   logic             rd_valid, rd_valid0;
   logic [LANES-1:0] rd_miss,  rd_miss0;
   logic             ld_ready, ld_ready0;
   logic             ld_busy,  ld_busy0;
   logic             ld_done,  ld_done0;

   rf_prime_bank #(.XLEN(XLEN), .DEPTH(DEPTH), .AR_BITS(AR_BITS), .LANES(LANES), .FWD(1)) dut (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_miss(rd_miss), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
      .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done));

   rf_prime_bank #(.XLEN(XLEN), .DEPTH(DEPTH), .AR_BITS(AR_BITS), .LANES(LANES), .FWD(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data0),
      .rd_valid(rd_valid0), .rd_miss(rd_miss0), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
      .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_ready(ld_ready0), .ld_busy(ld_busy0), .ld_done(ld_done0));

   int total = 0;
   int bad   = 0;

   // Reference model: table contents, written-since-reset flags, and the
   // load job as a list of addresses still to be filled.
   logic [XLEN-1:0] m_mem [DEPTH];
   bit              m_vld [DEPTH];
   int              m_q [$];
   bit              m_active = 0;
   bit              m_done   = 0;

   logic [DW-1:0]    e_data,  e_data0;
   logic [LANES-1:0] e_miss,  e_miss0;
   logic             e_valid;
   logic             e_ready, e_busy, e_done;
   logic             s_ready, s_busy, s_done, s_ready0, s_busy0, s_done0;

   function automatic logic [DW-1:0] lane_mask(input logic [LANES-1:0] miss);
      logic [DW-1:0] m;
      m = '0;
      for (int i = 0; i < LANES; i++) if (!miss[i]) m[i*XLEN +: XLEN] = '1;
      return m;
   endfunction

   task automatic model_step();
      bit              we;
      int              wa;
      logic [XLEN-1:0] wd;
      int              a;
      e_busy  = m_active;
      e_done  = m_done;
      e_ready = m_active && !m_done && (m_q.size() > 0) && !wr_en;
      we = 0; wa = 0; wd = '0;
      if (wr_en) begin
         we = 1; wa = int'(wr_adr); wd = wr_data;
      end else if (e_ready && ld_valid) begin
         we = 1; wa = m_q[0]; wd = ld_data;
      end
      e_valid = rd_en;
      if (rd_en) begin
         for (int i = 0; i < LANES; i++) begin
            a = (int'(rd_adr) + i) % DEPTH;
            e_data0[i*XLEN +: XLEN] = m_mem[a];
            e_miss0[i]              = !m_vld[a];
            if (we && wa == a) begin
               e_data[i*XLEN +: XLEN] = wd;
               e_miss[i]              = 1'b0;
            end else begin
               e_data[i*XLEN +: XLEN] = m_mem[a];
               e_miss[i]              = !m_vld[a];
            end
         end
      end
      if (we) begin
         m_mem[wa] = wd;
         m_vld[wa] = 1;
      end
      if (m_done) begin
         m_active = 0; m_done = 0;
      end else if (m_active) begin
         if (e_ready && ld_valid) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_done = 1;
         end
      end else if (ld_start) begin
         m_active = 1;
         for (int k = 0; k < int'(ld_count); k++) m_q.push_back((int'(ld_base) + k) % DEPTH);
         if (ld_count == '0) m_done = 1;
      end
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) m_vld[k] = 0;
         m_q.delete();
         m_active = 0; m_done = 0;
         e_data = '0; e_data0 = '0; e_miss = '1; e_miss0 = '1; e_valid = 0;
      end
   endtask

   task automatic tick();
      #1;
      s_ready = ld_ready;  s_busy = ld_busy;  s_done = ld_done;
      s_ready0 = ld_ready0; s_busy0 = ld_busy0; s_done0 = ld_done0;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rd_en = 0; rd_adr = '0; wr_en = 0; wr_adr = '0; wr_data = '0;
      ld_start = 0; ld_base = '0; ld_count = '0; ld_valid = 0; ld_data = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
      total++; if (rd_miss !== 2'b11) begin bad++; $display("FAIL reset_rd_miss got %b want 11", rd_miss); end
      total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
      tick();
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready got %0b want 0", s_ready); end
      total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL reset_ld_busy got %0b want 0", s_busy); end
      total++; if (s_done !== 1'b0) begin bad++; $display("FAIL reset_ld_done got %0b want 0", s_done); end
   endtask

   task automatic test_basic_rw();
      logic [DW-1:0] held;
      idle_inputs();
      rd_en = 1; rd_adr = 7'd5; tick();
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL miss_read_valid got %0b want 1", rd_valid); end
      total++; if (rd_miss !== 2'b11) begin bad++; $display("FAIL miss_read_miss got %b want 11", rd_miss); end
      idle_inputs();
      wr_en = 1; wr_adr = 7'd5; wr_data = 33'h1_0000_0001; tick();
      idle_inputs();
      rd_en = 1; rd_adr = 7'd5; tick();
      total++; if (rd_data[XLEN-1:0] !== 33'h1_0000_0001) begin bad++; $display("FAIL rw_lane0 got %h want 100000001", rd_data[XLEN-1:0]); end
      total++; if (rd_miss !== 2'b10) begin bad++; $display("FAIL rw_miss got %b want 10", rd_miss); end
      held = rd_data;
      idle_inputs(); tick();
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got %0b want 0", rd_valid); end
      total++; if (rd_data !== held) begin bad++; $display("FAIL idle_hold got %h want %h", rd_data, held); end
   endtask

   task automatic test_wrap();
      idle_inputs();
      wr_en = 1; wr_adr = 7'd127; wr_data = 33'h0_DEAD_BEEF; tick();
      wr_adr = 7'd0; wr_data = 33'h1_CAFE_F00D; tick();
      idle_inputs();
      rd_en = 1; rd_adr = 7'd127; tick();
      total++; if (rd_data[XLEN-1:0] !== 33'h0_DEAD_BEEF) begin bad++; $display("FAIL wrap_lane0 got %h want 0deadbeef", rd_data[XLEN-1:0]); end
      total++; if (rd_data[XLEN +: XLEN] !== 33'h1_CAFE_F00D) begin bad++; $display("FAIL wrap_lane1 got %h want 1cafef00d", rd_data[XLEN +: XLEN]); end
      total++; if (rd_miss !== 2'b00) begin bad++; $display("FAIL wrap_miss got %b want 00", rd_miss); end
   endtask

   task automatic test_forward();
      idle_inputs();
      wr_en = 1; wr_adr = 7'd9;  wr_data = 33'h0_0000_0909; tick();
      wr_adr = 7'd10; wr_data = 33'h0_0000_0A0A; tick();
      wr_data = 33'h1_2222_3333; rd_en = 1; rd_adr = 7'd9; tick();
      total++; if (rd_data[XLEN +: XLEN] !== 33'h1_2222_3333) begin bad++; $display("FAIL fwd1_lane1 got %h want 122223333", rd_data[XLEN +: XLEN]); end
      total++; if (rd_miss !== 2'b00) begin bad++; $display("FAIL fwd1_miss got %b want 00", rd_miss); end
      total++; if (rd_data0[XLEN +: XLEN] !== 33'h0_0000_0A0A) begin bad++; $display("FAIL fwd0_lane1 got %h want 000000a0a", rd_data0[XLEN +: XLEN]); end
      total++; if (rd_valid0 !== 1'b1) begin bad++; $display("FAIL fwd0_valid got %0b want 1", rd_valid0); end
      idle_inputs();
      rd_en = 1; rd_adr = 7'd9; tick();
      total++; if (rd_data0[XLEN +: XLEN] !== 33'h1_2222_3333) begin bad++; $display("FAIL fwd0_next_lane1 got %h want 122223333", rd_data0[XLEN +: XLEN]); end
   endtask

   task automatic test_load();
      logic [XLEN-1:0] d [4];
      int acc = 0, last_beat = -1, done_cyc = -1, dones = 0;
      d[0] = 33'h1_0000_00D0; d[1] = 33'h0_0000_00D1; d[2] = 33'h1_0000_00D2; d[3] = 33'h0_0000_00D3;
      idle_inputs();
      ld_start = 1; ld_base = 7'd126; ld_count = 8'd4; tick();
      for (int c = 0; c < 30 && done_cyc < 0; c++) begin
         idle_inputs();
         ld_valid = ((c % 3) != 1) && (acc < 4);
         ld_data  = (acc < 4) ? d[acc] : '0;
         if (c == 2) begin ld_start = 1; ld_base = 7'd60; ld_count = 8'd3; end
         tick();
         total++; if (s_ready !== e_ready) begin bad++; $display("FAIL load_ready c=%0d got %0b want %0b", c, s_ready, e_ready); end
         total++; if (s_busy !== e_busy) begin bad++; $display("FAIL load_busy c=%0d got %0b want %0b", c, s_busy, e_busy); end
         if (s_done) begin dones++; done_cyc = c; end
         if (s_ready && ld_valid) begin acc++; last_beat = c; end
      end
      total++; if (done_cyc != last_beat + 1 || acc != 4) begin bad++; $display("FAIL load_done_timing got done=%0d beats=%0d want done=%0d beats=4", done_cyc, acc, last_beat + 1); end
      idle_inputs(); tick();
      total++; if (s_busy !== 1'b0 || dones != 1) begin bad++; $display("FAIL load_end busy=%0b dones=%0d want 0/1", s_busy, dones); end
      rd_en = 1; rd_adr = 7'd126; tick();
      total++; if (rd_data !== {d[1], d[0]} || rd_miss !== 2'b00) begin bad++; $display("FAIL load_data_126 got %h/%b want %h/00", rd_data, rd_miss, {d[1], d[0]}); end
      rd_adr = 7'd0; tick();
      total++; if (rd_data !== {d[3], d[2]} || rd_miss !== 2'b00) begin bad++; $display("FAIL load_data_0 got %h/%b want %h/00", rd_data, rd_miss, {d[3], d[2]}); end
      rd_adr = 7'd60; tick();
      total++; if (rd_miss !== 2'b11) begin bad++; $display("FAIL load_ignored_start got %b want 11", rd_miss); end
   endtask

   task automatic test_load_wr_collision();
      logic [XLEN-1:0] l [5];
      int acc = 0, c = 0;
      for (int k = 0; k < 5; k++) l[k] = 33'h1_2345_6780 + 33'(k);
      idle_inputs();
      ld_start = 1; ld_base = 7'd80; ld_count = 8'd5; tick();
      while (!s_done && c < 30) begin
         idle_inputs();
         ld_valid = (acc < 5);
         ld_data  = (acc < 5) ? l[acc] : '0;
         if (c >= 1 && c <= 3) begin wr_en = 1; wr_adr = 7'(99 + c); wr_data = 33'h0_0000_0100 + 33'(c); end
         tick();
         total++; if (s_ready !== e_ready) begin bad++; $display("FAIL coll_ready c=%0d got %0b want %0b", c, s_ready, e_ready); end
         if (wr_en) begin
            total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL coll_ready_wr c=%0d got %0b want 0", c, s_ready); end
         end
         if (s_ready && ld_valid) acc++;
         c++;
      end
      total++; if (c >= 30) begin bad++; $display("FAIL coll_timeout got %0d cycles want done", c); end
      idle_inputs(); tick();
      rd_en = 1; rd_adr = 7'd80; tick();
      total++; if (rd_data !== {l[1], l[0]}) begin bad++; $display("FAIL coll_80 got %h want %h", rd_data, {l[1], l[0]}); end
      rd_adr = 7'd82; tick();
      total++; if (rd_data !== {l[3], l[2]}) begin bad++; $display("FAIL coll_82 got %h want %h", rd_data, {l[3], l[2]}); end
      rd_adr = 7'd84; tick();
      total++; if (rd_data[XLEN-1:0] !== l[4] || rd_miss !== 2'b10) begin bad++; $display("FAIL coll_84 got %h/%b want %h/10", rd_data[XLEN-1:0], rd_miss, l[4]); end
      rd_adr = 7'd100; tick();
      total++; if (rd_data !== {33'h0_0000_0102, 33'h0_0000_0101}) begin bad++; $display("FAIL coll_wr100 got %h want 101/102", rd_data); end
      rd_adr = 7'd102; tick();
      total++; if (rd_data[XLEN-1:0] !== 33'h0_0000_0103 || rd_miss !== 2'b10) begin bad++; $display("FAIL coll_wr102 got %h/%b want 103/10", rd_data[XLEN-1:0], rd_miss); end
   endtask

   task automatic test_load_zero();
      idle_inputs();
      ld_start = 1; ld_base = 7'd30; ld_count = 8'd0; tick();
      idle_inputs(); tick();
      total++; if (s_done !== 1'b1) begin bad++; $display("FAIL zero_done got %0b want 1", s_done); end
      tick();
      total++; if (s_busy !== 1'b0 || s_done !== 1'b0) begin bad++; $display("FAIL zero_after busy=%0b done=%0b want 0/0", s_busy, s_done); end
      rd_en = 1; rd_adr = 7'd30; tick();
      total++; if (rd_miss !== 2'b11) begin bad++; $display("FAIL zero_bitmap got %b want 11", rd_miss); end
   endtask

   task automatic test_reset_midload();
      idle_inputs();
      ld_start = 1; ld_base = 7'd40; ld_count = 8'd5; tick();
      idle_inputs();
      ld_valid = 1; ld_data = 33'h1_1111_1111; tick();
      ld_data = 33'h0_2222_2222; tick();
      rst_n = 0; tick();
      rst_n = 1; idle_inputs();
      rd_en = 1; rd_adr = 7'd40; tick();
      total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL rstload_busy got %0b want 0", s_busy); end
      total++; if (s_done !== 1'b0) begin bad++; $display("FAIL rstload_done got %0b want 0", s_done); end
      total++; if (rd_miss !== 2'b11) begin bad++; $display("FAIL rstload_miss40 got %b want 11", rd_miss); end
      rd_adr = 7'd5; tick();
      total++; if (rd_miss !== 2'b11) begin bad++; $display("FAIL rstload_miss5 got %b want 11", rd_miss); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         idle_inputs();
         rd_en    = ($urandom_range(0, 3) != 0);
         rd_adr   = 7'($urandom);
         wr_en    = ($urandom_range(0, 4) == 0);
         wr_adr   = ($urandom_range(0, 1) == 0) ? rd_adr + 7'($urandom_range(0, 1)) : 7'($urandom);
         wr_data  = {1'($urandom), 32'($urandom)};
         ld_start = ($urandom_range(0, 15) == 0);
         ld_base  = 7'($urandom);
         ld_count = 8'($urandom_range(0, 12));
         ld_valid = ($urandom_range(0, 2) != 0);
         ld_data  = {1'($urandom), 32'($urandom)};
         tick();
         total++; if (rd_valid !== e_valid) begin bad++; $display("FAIL rnd_valid c=%0d got %0b want %0b", c, rd_valid, e_valid); end
         total++; if (rd_miss !== e_miss) begin bad++; $display("FAIL rnd_miss c=%0d got %b want %b", c, rd_miss, e_miss); end
         total++; if ((rd_data & lane_mask(e_miss)) !== (e_data & lane_mask(e_miss))) begin bad++; $display("FAIL rnd_data c=%0d got %h want %h", c, rd_data & lane_mask(e_miss), e_data & lane_mask(e_miss)); end
         total++; if (rd_miss0 !== e_miss0) begin bad++; $display("FAIL rnd_miss_nofwd c=%0d got %b want %b", c, rd_miss0, e_miss0); end
         total++; if ((rd_data0 & lane_mask(e_miss0)) !== (e_data0 & lane_mask(e_miss0))) begin bad++; $display("FAIL rnd_data_nofwd c=%0d got %h want %h", c, rd_data0 & lane_mask(e_miss0), e_data0 & lane_mask(e_miss0)); end
         total++; if ({s_ready, s_busy, s_done} !== {e_ready, e_busy, e_done}) begin bad++; $display("FAIL rnd_ld c=%0d got %b want %b", c, {s_ready, s_busy, s_done}, {e_ready, e_busy, e_done}); end
         total++; if ({s_ready0, s_busy0, s_done0} !== {e_ready, e_busy, e_done}) begin bad++; $display("FAIL rnd_ld_nofwd c=%0d got %b want %b", c, {s_ready0, s_busy0, s_done0}, {e_ready, e_busy, e_done}); end
      end
   endtask

   initial begin
      for (int k = 0; k < DEPTH; k++) begin m_mem[k] = '0; m_vld[k] = 0; end
      e_data = '0; e_data0 = '0; e_miss = '1; e_miss0 = '1; e_valid = 0;
      rst_n = 0;
      test_reset();
      test_basic_rw();
      test_wrap();
      test_forward();
      test_load();
      test_load_wr_collision();
      test_load_zero();
      test_reset_midload();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
